// File: rtl/pingpong_feature_buffer.sv
`default_nettype none
// ============================================================================
// Module      : pingpong_feature_buffer
// Description : Double-buffered feature-map store. A producer fills one bank
//               while a consumer reads the previously completed frame from
//               the other; bank ownership moves on frame-level done pulses.
//               Read data is returned with a valid strobe after 1 or 2 cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module pingpong_feature_buffer #(
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_SIZE     = 28*28,
  parameter int READ_LATENCY = 1,
  parameter int ADDR_WIDTH   = $clog2(MEM_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Enable_Write,
  input  logic [ADDR_WIDTH-1:0] Write_Address,
  input  logic [DATA_WIDTH-1:0] Data_Input,
  input  logic                  Write_Done,
  output logic                  Write_Ready,
  output logic                  Write_Bank,
  input  logic                  Enable_Read,
  input  logic [ADDR_WIDTH-1:0] Read_Address,
  input  logic                  Read_Done,
  output logic                  Frame_Available,
  output logic                  Read_Bank,
  output logic [DATA_WIDTH-1:0] Data_Output,
  output logic                  Data_Valid
);

  typedef enum logic {
    BANK_EMPTY = 1'b0,
    BANK_FULL  = 1'b1
  } bank_state_t;

  // Widened by one bit so the bound stays exact even when MEM_SIZE is 2**N.
  localparam logic [ADDR_WIDTH:0] c_mem_size = (ADDR_WIDTH+1)'(MEM_SIZE);

  logic [DATA_WIDTH-1:0] mem [2][MEM_SIZE];

  logic [1:0] full;
  logic       wr_sel;
  logic       rd_sel;

  logic write_accept;
  logic write_in_range;
  logic write_done_accept;
  logic read_accept;
  logic read_in_range;
  logic read_done_accept;

  logic                  s1_valid;
  logic [DATA_WIDTH-1:0] s1_data;

  assign Write_Ready     = !full[wr_sel];
  assign Frame_Available = full[rd_sel];
  assign Write_Bank      = wr_sel;
  assign Read_Bank       = rd_sel;

  assign write_accept      = Enable_Write && Write_Ready;
  assign write_in_range    = ({1'b0, Write_Address} < c_mem_size);
  assign write_done_accept = Write_Done && Write_Ready;
  assign read_accept       = Enable_Read && Frame_Available;
  assign read_in_range     = ({1'b0, Read_Address} < c_mem_size);
  assign read_done_accept  = Read_Done && Frame_Available;

  // Per-bank ownership FSM: a bank fills only as the write bank and drains
  // only as the read bank. The write bank is always empty and the read bank
  // always full, so simultaneous done pulses never hit the same bank.
  generate
    for (genvar b = 0; b < 2; b++) begin : g_bank
      bank_state_t state;
      bank_state_t state_next;

      // Bank state register.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= BANK_EMPTY;
        else     state <= state_next;
      end

      // Bank next-state decode.
      always_comb begin
        state_next = state;
        case (state)
          BANK_EMPTY: if (write_done_accept && (wr_sel == 1'(b))) state_next = BANK_FULL;
          BANK_FULL:  if (read_done_accept  && (rd_sel == 1'(b))) state_next = BANK_EMPTY;
          default:    state_next = BANK_EMPTY;
        endcase
      end

      assign full[b] = (state == BANK_FULL);
    end
  endgenerate

  // Bank selectors toggle whenever their side hands a bank over.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
    end else begin
      if (write_done_accept) wr_sel <= ~wr_sel;
      if (read_done_accept)  rd_sel <= ~rd_sel;
    end
  end

  // Storage write port; contents survive reset, out-of-range writes are dropped.
  always_ff @(posedge clk) begin
    if (write_accept && write_in_range) mem[wr_sel][Write_Address] <= Data_Input;
  end

  // First read stage: captures data at the accepting edge, holds otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= read_accept;
      if (read_accept) s1_data <= read_in_range ? mem[rd_sel][Read_Address] : '0;
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                  s2_valid;
      logic [DATA_WIDTH-1:0] s2_data;

      // Extra output stage; data only advances with a valid result so it holds.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s2_valid <= 1'b0;
          s2_data  <= '0;
        end else begin
          s2_valid <= s1_valid;
          if (s1_valid) s2_data <= s1_data;
        end
      end

      assign Data_Valid  = s2_valid;
      assign Data_Output = s2_data;
    end else begin : g_lat1
      assign Data_Valid  = s1_valid;
      assign Data_Output = s1_data;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pingpong_feature_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pingpong_feature_buffer
// Description : Directed self-checking bench; drives one latency-1 and one
//               latency-2 instance with identical stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pingpong_feature_buffer;

  localparam int DW = 32;
  localparam int MS = 28*28;
  localparam int AW = $clog2(MS);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          we = 1'b0;
  logic [AW-1:0] wa = '0;
  logic [DW-1:0] di = '0;
  logic          wd = 1'b0;
  logic          re = 1'b0;
  logic [AW-1:0] ra = '0;
  logic          rd = 1'b0;

  logic          wr_rdy1, wr_bank1, fa1, rd_bank1, dv1;
  logic [DW-1:0] do1;
  logic          wr_rdy2, wr_bank2, fa2, rd_bank2, dv2;
  logic [DW-1:0] do2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pingpong_feature_buffer #(.DATA_WIDTH(DW), .MEM_SIZE(MS), .READ_LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .Enable_Write(we), .Write_Address(wa), .Data_Input(di), .Write_Done(wd),
    .Write_Ready(wr_rdy1), .Write_Bank(wr_bank1),
    .Enable_Read(re), .Read_Address(ra), .Read_Done(rd),
    .Frame_Available(fa1), .Read_Bank(rd_bank1),
    .Data_Output(do1), .Data_Valid(dv1)
  );

  pingpong_feature_buffer #(.DATA_WIDTH(DW), .MEM_SIZE(MS), .READ_LATENCY(2)) u_dut2 (
    .clk(clk), .rst(rst),
    .Enable_Write(we), .Write_Address(wa), .Data_Input(di), .Write_Done(wd),
    .Write_Ready(wr_rdy2), .Write_Bank(wr_bank2),
    .Enable_Read(re), .Read_Address(ra), .Read_Done(rd),
    .Frame_Available(fa2), .Read_Bank(rd_bank2),
    .Data_Output(do2), .Data_Valid(dv2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [DW-1:0] base);
    for (int a = 0; a < MS; a++) begin
      we = 1'b1;
      wa = AW'(a);
      di = base + DW'(a);
      step();
    end
    we = 1'b0;
  endtask

  task automatic pulse_wd();
    wd = 1'b1;
    step();
    wd = 1'b0;
  endtask

  task automatic pulse_rd();
    rd = 1'b1;
    step();
    rd = 1'b0;
  endtask

  // Single read: latency-1 result after one edge, latency-2 after two.
  task automatic read_one(input string tag, input logic [AW-1:0] addr, input logic [DW-1:0] exp);
    re = 1'b1;
    ra = addr;
    step();
    re = 1'b0;
    check({tag, "_dv1"}, dv1, 1);
    check({tag, "_do1"}, do1, exp);
    check({tag, "_dv2_early"}, dv2, 0);
    step();
    check({tag, "_dv2"}, dv2, 1);
    check({tag, "_do2"}, do2, exp);
    check({tag, "_dv1_off"}, dv1, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [AW-1:0] addrs [3];
    addrs[0] = 0; addrs[1] = 5; addrs[2] = 783;

    // Reset state
    #2;
    check("rst_wr_rdy", wr_rdy1, 1);
    check("rst_fa", fa1, 0);
    check("rst_wb", wr_bank1, 0);
    check("rst_rb", rd_bank1, 0);
    check("rst_dv1", dv1, 0);
    check("rst_do1", do1, 0);
    check("rst_dv2", dv2, 0);
    check("rst_do2", do2, 0);
    step();
    step();
    rst = 1'b0;
    step();

    // Fill bank 0 with data = address and commit
    fill(32'h0);
    check("pre_commit_fa", fa1, 0);
    pulse_wd();
    check("commit_wb", wr_bank1, 1);
    check("commit_fa1", fa1, 1);
    check("commit_fa2", fa2, 1);
    check("commit_wr_rdy", wr_rdy1, 1);

    // Back-to-back reads of 0, 5, 783
    for (int i = 0; i < 3; i++) begin
      re = 1'b1;
      ra = addrs[i];
      step();
      check("b2b_dv1", dv1, 1);
      check("b2b_do1", do1, DW'(addrs[i]));
      if (i == 0) check("b2b_dv2_first", dv2, 0);
      else begin
        check("b2b_dv2", dv2, 1);
        check("b2b_do2", do2, DW'(addrs[i-1]));
      end
    end
    re = 1'b0;
    step();
    check("b2b_dv1_off", dv1, 0);
    check("b2b_do1_hold", do1, 783);
    check("b2b_dv2_last", dv2, 1);
    check("b2b_do2_last", do2, 783);
    step();
    check("b2b_dv2_off", dv2, 0);
    check("b2b_do2_hold", do2, 783);

    // Out-of-range read returns 0 with valid
    read_one("oor", AW'(784), 32'h0);
    step();

    // Continuous burst 10..19
    for (int i = 0; i < 10; i++) begin
      re = 1'b1;
      ra = AW'(10 + i);
      step();
      check("burst_dv1", dv1, 1);
      check("burst_do1", do1, DW'(10 + i));
      if (i == 0) check("burst_dv2_first", dv2, 0);
      else begin
        check("burst_dv2", dv2, 1);
        check("burst_do2", do2, DW'(9 + i));
      end
    end
    re = 1'b0;
    step();
    check("burst_dv2_last", dv2, 1);
    check("burst_do2_last", do2, 19);
    step();
    check("burst_dv2_off", dv2, 0);

    // Fill bank 1, both banks full
    fill(32'hAAAA_0000);
    pulse_wd();
    check("both_full_wr_rdy", wr_rdy1, 0);
    check("both_full_wb", wr_bank1, 0);
    we = 1'b1; wa = '0; di = 32'hDEAD;
    step();
    we = 1'b0;
    pulse_wd();
    check("ignored_wd_wb", wr_bank1, 0);
    check("ignored_wd_wr_rdy", wr_rdy2, 0);
    read_one("dropped_write", AW'(0), 32'h0);
    pulse_rd();
    check("rdone_wr_rdy", wr_rdy1, 1);
    check("rdone_rb", rd_bank1, 1);
    check("rdone_fa", fa1, 1);
    read_one("bank1_a0", AW'(0), 32'hAAAA_0000);

    // Simultaneous Write_Done/Read_Done with same-cycle write and read
    we = 1'b1; wa = AW'(7); di = 32'h1234; wd = 1'b1;
    re = 1'b1; ra = AW'(3); rd = 1'b1;
    step();
    we = 1'b0; wd = 1'b0; re = 1'b0; rd = 1'b0;
    check("swap_wb", wr_bank1, 1);
    check("swap_rb", rd_bank1, 0);
    check("swap_wr_rdy", wr_rdy1, 1);
    check("swap_fa", fa1, 1);
    check("swap_dv1", dv1, 1);
    check("swap_do1", do1, 32'hAAAA_0003);
    step();
    check("swap_dv2", dv2, 1);
    check("swap_do2", do2, 32'hAAAA_0003);
    read_one("sameclk_write", AW'(7), 32'h1234);

    // Drain bank 0 -> both empty; reads produce nothing
    pulse_rd();
    check("empty_fa", fa1, 0);
    check("empty_rb", rd_bank1, 1);
    pulse_rd();
    check("ignored_rd_rb", rd_bank1, 1);
    re = 1'b1; ra = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("noframe_dv1", dv1, 0);
      check("noframe_dv2", dv2, 0);
    end
    re = 1'b0;
    step();
    check("noframe_dv2_tail", dv2, 0);

    // Commit bank 1, start a read, reset mid-flight
    we = 1'b1; wa = AW'(2); di = 32'h55;
    step();
    we = 1'b0;
    pulse_wd();
    check("b1_fa", fa1, 1);
    check("b1_wb", wr_bank1, 0);
    re = 1'b1; ra = AW'(2);
    step();
    check("flight_dv1", dv1, 1);
    check("flight_do1", do1, 32'h55);
    check("flight_dv2_pending", dv2, 0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_dv1", dv1, 0);
    check("arst_dv2", dv2, 0);
    check("arst_do2", do2, 0);
    check("arst_fa", fa1, 0);
    check("arst_wb", wr_bank1, 0);
    check("arst_rb", rd_bank1, 0);
    check("arst_wr_rdy", wr_rdy1, 1);
    re = 1'b0;
    step();
    rst = 1'b0;
    step();
    check("post_rst_dv1", dv1, 0);
    check("post_rst_dv2", dv2, 0);
    step();
    check("post_rst_dv2_b", dv2, 0);
    check("post_rst_fa2", fa2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pingpong_feature_buffer.md
# pingpong_feature_buffer

Double-buffered (ping-pong) feature-map memory for the LeNet5 layer pipeline; it supersedes the single-port frame store. A producer layer fills one bank while a consumer layer reads the previously completed frame from the other. Bank ownership changes through a frame-level done/ready handshake. Read latency is selectable at 1 or 2 cycles, and every read result carries a valid strobe.

## Interface
- DATA_WIDTH, 32, word width in bits.
- MEM_SIZE, 28*28, words per bank; each bank holds one feature map.
- READ_LATENCY, 1, cycles from an accepted read to Data_Valid; legal values are 1 and 2.
- ADDR_WIDTH, $clog2(MEM_SIZE), address width.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- Enable_Write  in  1  write strobe from the producer.
- Write_Address  in  ADDR_WIDTH  word address within the current write bank.
- Data_Input  in  DATA_WIDTH  write data.
- Write_Done  in  1  one-cycle pulse: the current write bank holds a complete frame.
- Write_Ready  out  1  the current write bank is free for writing.
- Write_Bank  out  1  index of the current write bank.
- Enable_Read  in  1  read strobe from the consumer.
- Read_Address  in  ADDR_WIDTH  word address within the current read bank.
- Read_Done  in  1  one-cycle pulse: the consumer has finished with the current read bank.
- Frame_Available  out  1  the current read bank holds a complete frame.
- Read_Bank  out  1  index of the current read bank.
- Data_Output  out  DATA_WIDTH  read data.
- Data_Valid  out  1  Data_Output carries the result of a read accepted READ_LATENCY cycles earlier.

## Operation
- Storage: two banks of MEM_SIZE x DATA_WIDTH. Reset does not clear bank contents.
- State registers: full[1:0], wr_sel, rd_sel. Reset values are full=00, wr_sel=0, rd_sel=0.
- Write_Ready = !full[wr_sel]. Frame_Available = full[rd_sel]. Write_Bank = wr_sel. Read_Bank = rd_sel.
- Accepted write = Enable_Write && Write_Ready. It writes Data_Input to bank[wr_sel][Write_Address]. A write while !Write_Ready is dropped.
- Write_Done while Write_Ready:
  - full[wr_sel] <= 1 and wr_sel toggles.
  - A write accepted in the same cycle lands in the old bank before the commit.
  - Write_Done while !Write_Ready is ignored.
- Accepted read = Enable_Read && Frame_Available. It reads bank[rd_sel][Read_Address]. A read while !Frame_Available produces no Data_Valid.
- Read_Done while Frame_Available:
  - full[rd_sel] <= 0 and rd_sel toggles.
  - A read accepted in the same cycle reads the old bank and still returns valid data.
  - Read_Done while !Frame_Available is ignored.
- Simultaneous Write_Done and Read_Done: both take effect in the same cycle. The two always target different banks, because the write bank is empty and the read bank is full.
- Both banks full: Write_Ready=0 and the producer stalls until Read_Done.
- Both banks empty: Frame_Available=0 and the consumer stalls.
- Address >= MEM_SIZE:
  - a write is dropped and memory is unchanged;
  - a read returns 0 with Data_Valid still asserted at the normal latency.
- Bank FSM, per bank: EMPTY -> FULL on Write_Done while the bank is the write bank; FULL -> EMPTY on Read_Done while the bank is the read bank. No other transitions.

## Timing
- Write_Ready, Frame_Available, Write_Bank and Read_Bank are combinational from the state registers. They update one cycle after the Done pulse edge.
- A frame committed by Write_Done at edge k can be read from edge k+1 at the earliest, i.e. Frame_Available=1 in the cycle after k, when rd_sel points to that bank.
- READ_LATENCY=1:
  - Data_Output and Data_Valid are registered at the edge that accepts the read.
  - Data_Valid is high for the following cycle.
- READ_LATENCY=2: one additional output register stage; Data_Valid is high 2 cycles after acceptance.
- Back-to-back reads give one result per cycle; Data_Valid stays high continuously.
- Data_Output holds its last value when Data_Valid=0.
- Reset, asynchronous and effective immediately:
  - Data_Output=0, Data_Valid=0, Write_Ready=1, Frame_Available=0, Write_Bank=0, Read_Bank=0;
  - the read pipeline is flushed.
- Reset mid-frame: partially written or unread frames are discarded. Reads in flight produce no Data_Valid.

## Test plan
- Reset, then fill bank 0 with data = address (0..783) and pulse Write_Done -> Write_Bank=1 and Frame_Available=1 next cycle. Reads of addresses 0, 5, 783 return 0, 5, 783 with Data_Valid exactly READ_LATENCY cycles later.
- Fill bank 0 (Write_Done), then fill bank 1 with 0xAAAA_0000+addr (Write_Done) -> Write_Ready=0. A further write of 0xDEAD to address 0 is dropped. Read_Done -> Write_Ready=1 and Read_Bank=1. Read address 0 returns 0xAAAA_0000.
- Assert Write_Done and Read_Done in the same cycle with one bank full -> full flags swap, both selectors toggle, Write_Ready=1, Frame_Available=1.
- Enable_Read with Frame_Available=0 -> Data_Valid stays 0 for 3 cycles. Read address 784 on a full bank -> Data_Output=0 with Data_Valid=1.
- Repeat the first scenario with READ_LATENCY=2 and a continuous read burst of addresses 10..19 -> Data_Valid high for 10 consecutive cycles starting 2 cycles after the first read, returning 10..19 in order.
- Assert rst while a read is in flight and bank 1 is full -> Data_Valid=0 immediately, Frame_Available=0, Write_Bank=0, no valid result after rst is released.
